// File: rtl/mem_arbiter.sv
// Serializes the CPU's I-Mem and D-Mem ports onto one physical-memory port.
// Build option MEM_ARBITER_RR_EN: round-robin on simultaneous requests (default: fixed D priority).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no pmem request; grant a pending I or D request
// I_BUSY | pmem request on behalf of the I-port, waiting for pmem_resp
// D_BUSY | pmem request on behalf of the D-port, waiting for pmem_resp
// RESP   | one-cycle completion pulse to the owning port
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  imem_read,
    input  logic [ADDR_W-1:0]     imem_address,
    output logic                  imem_resp,
    output logic [DATA_W-1:0]     imem_rdata,

    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic [ADDR_W-1:0]     dmem_address,
    input  logic [DATA_W/8-1:0]   dmem_byte_enable,
    input  logic [DATA_W-1:0]     dmem_wdata,
    output logic                  dmem_resp,
    output logic [DATA_W-1:0]     dmem_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_W-1:0]     pmem_address,
    output logic [DATA_W/8-1:0]   pmem_byte_enable,
    output logic [DATA_W-1:0]     pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [DATA_W-1:0]     pmem_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              i_req, d_req;
    logic              grant_i, grant_d;
    logic              busy;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              write_q;
    logic              owner_d_q;
    logic [DATA_W-1:0] irdata_q, drdata_q;

    assign i_req = imem_read;
    assign d_req = dmem_read | dmem_write;
    assign busy  = (state_q == I_BUSY) || (state_q == D_BUSY);

`ifdef MEM_ARBITER_RR_EN
    // last_d_q = 1 when the D-port won the most recent grant; the other port wins ties
    logic last_d_q;

    always_comb begin
        grant_d = d_req && (!i_req || !last_d_q);
        grant_i = i_req && !grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b1;
        end else if ((state_q == IDLE) && (grant_i || grant_d)) begin
            last_d_q <= grant_d;
        end
    end
`else
    always_comb begin
        grant_d = d_req;
        grant_i = i_req && !d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_BUSY;
                end else if (grant_i) begin
                    state_d = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pmem_read  = busy && !write_q;
        pmem_write = busy && write_q;
        imem_resp  = (state_q == RESP) && !owner_d_q;
        dmem_resp  = (state_q == RESP) && owner_d_q;
    end

    // Request registers: the only source of pmem_* while a transaction is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            write_q   <= 1'b0;
            owner_d_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (grant_d) begin
                addr_q    <= dmem_address & WORD_MASK;
                wdata_q   <= dmem_wdata;
                be_q      <= dmem_byte_enable;
                write_q   <= dmem_write;
                owner_d_q <= 1'b1;
            end else if (grant_i) begin
                addr_q    <= imem_address & WORD_MASK;
                wdata_q   <= '0;
                be_q      <= '1;
                write_q   <= 1'b0;
                owner_d_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irdata_q <= '0;
            drdata_q <= '0;
        end else if (busy && pmem_resp) begin
            if (state_q == I_BUSY) begin
                irdata_q <= pmem_rdata;
            end else begin
                drdata_q <= pmem_rdata;
            end
        end
    end

    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;
    assign imem_rdata       = irdata_q;
    assign dmem_rdata       = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected pmem requests and port
// responses; a pmem responder and a response monitor pop and compare independently.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        pmem_read, pmem_write;
    logic [31:0] pmem_address;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_wdata;
    logic        pmem_resp;
    logic [31:0] pmem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_byte_enable(pmem_byte_enable), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [31:0] rdata;
        int          lat;
    } pm_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        chk_data;
        int          exp_cyc;
    } rs_t;

    pm_t pq[$];
    rs_t rq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_cyc = -10;
    logic auto_resp = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // pmem responder: accept request, compare fields, hold for lat cycles, pulse pmem_resp
    initial begin
        pm_t e;
        logic held_ok;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (auto_resp) pmem_resp = 1'b0;
            if (auto_resp && (pmem_read || pmem_write)) begin
                if (pq.size() == 0) begin
                    chk("pmem_unexpected_grant", {pmem_read, pmem_write}, 2'b00);
                    pmem_resp = 1'b1;
                end else begin
                    e = pq.pop_front();
                    chk("pmem_read",  pmem_read, !e.wr);
                    chk("pmem_write", pmem_write, e.wr);
                    chk("pmem_address", pmem_address, e.addr);
                    chk("pmem_byte_enable", pmem_byte_enable, e.be);
                    if (e.chk_wdata) chk("pmem_wdata", pmem_wdata, e.wdata);
                    held_ok = 1'b1;
                    for (int k = 0; k < e.lat; k++) begin
                        @(negedge clk);
                        if (pmem_write !== e.wr || pmem_read !== !e.wr ||
                            pmem_address !== e.addr || pmem_byte_enable !== e.be ||
                            (e.chk_wdata && pmem_wdata !== e.wdata))
                            held_ok = 1'b0;
                    end
                    if (e.lat > 0) chk("pmem_held", held_ok, 1'b1);
                    pmem_rdata = e.rdata;
                    pmem_resp  = 1'b1;
                    resp_cyc   = cyc;
                end
            end
        end
    end

    // response monitor
    initial begin
        rs_t r;
        forever begin
            @(negedge clk);
            if (imem_resp && dmem_resp) chk("both_resp", 2'b11, 2'b00);
            if (imem_resp || dmem_resp) begin
                if (rq.size() == 0) begin
                    chk("unexpected_resp", {imem_resp, dmem_resp}, 2'b00);
                end else begin
                    r = rq.pop_front();
                    chk("resp_port_d", dmem_resp, r.is_d);
                    if (r.chk_data) chk("resp_rdata", r.is_d ? dmem_rdata : imem_rdata, r.data);
                    chk("resp_after_pmem_resp", cyc, resp_cyc + 1);
                    if (r.exp_cyc >= 0) chk("resp_latency", cyc, r.exp_cyc);
                end
            end
        end
    end

    // requesters drop at the edge ending their resp cycle
    initial forever begin
        @(negedge clk);
        if (imem_resp) begin @(posedge clk); #1 imem_read = 1'b0; end
    end
    initial forever begin
        @(negedge clk);
        if (dmem_resp) begin @(posedge clk); #1 dmem_read = 1'b0; dmem_write = 1'b0; end
    end

    task automatic exp_i(input logic [31:0] addr, input logic [31:0] data, input int lat, input int ec);
        pq.push_back('{1'b0, addr & 32'hFFFF_FFFC, 4'hF, 32'h0, 1'b0, data, lat});
        rq.push_back('{1'b0, data, 1'b1, ec});
    endtask

    task automatic exp_d(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] data, input int lat, input int ec);
        pq.push_back('{wr, addr & 32'hFFFF_FFFC, be, wd, wr, data, lat});
        rq.push_back('{1'b1, data, !wr, ec});
    endtask

    task automatic drive_i(input logic [31:0] addr);
        imem_read = 1'b1; imem_address = addr;
    endtask

    task automatic drive_d(input logic wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        dmem_read = !wr; dmem_write = wr; dmem_address = addr;
        dmem_byte_enable = be; dmem_wdata = wd;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((pq.size() != 0 || rq.size() != 0) && n < budget) begin
            @(negedge clk); n++;
        end
        if (pq.size() != 0 || rq.size() != 0) begin
            chk("timeout_outstanding", pq.size() + rq.size(), 0);
            pq.delete(); rq.delete();
        end
        @(posedge clk); #2;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        imem_read = 0; imem_address = 0;
        dmem_read = 0; dmem_write = 0; dmem_address = 0; dmem_byte_enable = 0; dmem_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_imem_resp", imem_resp, 1'b0);
        chk("rst_dmem_resp", dmem_resp, 1'b0);
        chk("rst_pmem_address", pmem_address, 32'h0);
        chk("rst_pmem_wdata", pmem_wdata, 32'h0);
        chk("rst_pmem_be", pmem_byte_enable, 4'h0);
        chk("rst_imem_rdata", imem_rdata, 32'h0);
        chk("rst_dmem_rdata", dmem_rdata, 32'h0);
        @(posedge clk); #2;

        exp_i(32'h0000_0062, 32'hDEAD_BEEF, 3, -1);
        drive_i(32'h0000_0062);
        wait_done(40);

        exp_d(1'b1, 32'h0000_0100, 4'h4, 32'h00AB_0000, 32'h0, 2, -1);
        drive_d(1'b1, 32'h0000_0100, 4'h4, 32'h00AB_0000);
        wait_done(40);

        exp_d(1'b0, 32'h0000_0207, 4'hF, 32'h0, 32'h1234_5678, 1, -1);
        drive_d(1'b0, 32'h0000_0207, 4'hF, 32'h0);
        wait_done(40);
        chk("imem_rdata_hold", imem_rdata, 32'hDEAD_BEEF);

        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_RR_EN
            exp_i(32'h800 + 32'(k * 16), 32'h1000_0000 + 32'(k), 1, -1);
            exp_d(1'b0, 32'h400 + 32'(k * 16), 4'hF, 32'h0, 32'hD000_0000 + 32'(k), 1, -1);
`else
            exp_d(1'b0, 32'h400 + 32'(k * 16), 4'hF, 32'h0, 32'hD000_0000 + 32'(k), 1, -1);
            exp_i(32'h800 + 32'(k * 16), 32'h1000_0000 + 32'(k), 1, -1);
`endif
            drive_d(1'b0, 32'h400 + 32'(k * 16), 4'hF, 32'h0);
            drive_i(32'h800 + 32'(k * 16));
            wait_done(60);
        end

        // zero-wait pmem, back-to-back requests from the same port
        exp_i(32'h0000_0A00, 32'hCAFE_0001, 0, cyc + 2);
        drive_i(32'h0000_0A00);
        wait_done(20);
        exp_i(32'h0000_0A04, 32'hCAFE_0002, 0, cyc + 2);
        drive_i(32'h0000_0A04);
        wait_done(20);
        exp_d(1'b0, 32'h0000_0B00, 4'hF, 32'h0, 32'hCAFE_0003, 0, cyc + 2);
        drive_d(1'b0, 32'h0000_0B00, 4'hF, 32'h0);
        wait_done(20);
        chk("zw_imem_rdata_hold", imem_rdata, 32'hCAFE_0002);

        // reset while D_BUSY, late pmem_resp afterwards
        auto_resp = 1'b0;
        drive_d(1'b0, 32'h0000_0300, 4'hF, 32'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (!pmem_read && n < 10);
        chk("rst_test_busy_pmem_read", pmem_read, 1'b1);
        @(posedge clk); #1 rst = 1'b1; dmem_read = 1'b0;
        @(posedge clk); #1 rst = 1'b0; pmem_resp = 1'b1; pmem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("midrst_pmem_read", pmem_read, 1'b0);
        chk("midrst_pmem_write", pmem_write, 1'b0);
        chk("midrst_dmem_rdata", dmem_rdata, 32'h0);
        chk("midrst_imem_rdata", imem_rdata, 32'h0);
        chk("midrst_pmem_address", pmem_address, 32'h0);
        @(posedge clk); #1 pmem_resp = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_resp_ignored_rdata", dmem_rdata, 32'h0);
        chk("late_resp_idle", pmem_read | pmem_write, 1'b0);
        auto_resp = 1'b1;
        @(posedge clk); #2;

        exp_d(1'b0, 32'h0000_0310, 4'hF, 32'h0, 32'h5A5A_A5A5, 0, cyc + 2);
        drive_d(1'b0, 32'h0000_0310, 4'hF, 32'h0);
        wait_done(20);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=done", cyc);
        $fatal(1, "timeout");
    end

endmodule
